load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_align.sv | 96 +++++++++
 rtl/load_store_unit.sv | 214 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared definitions for the MEM-stage load/store unit:
//             funct3 access-size encodings, FSM state type and the default
//             bus timeout.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    // funct3 encodings for loads/stores
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Default cycles allowed in REQ or RESP before an access is aborted
    localparam int c_timeout_default = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Combinational byte-lane logic for the load/store unit.
//             - legality and alignment check of the incoming access
//             - store strobe generation and lane replication of store data
//             - load byte/half extraction with sign or zero extension
//  Ports    : i_is_load/i_is_store  access type (store wins if both)
//             i_funct3, i_addr_lo    size/sign and low address bits (issue)
//             i_wdata                raw store data
//             i_ld_funct3, i_ld_lo   size/sign and low address of the
//                                    outstanding load
//             i_rword                word returned by memory
//             o_illegal, o_misaligned, o_wstrb, o_wdata, o_rdata
//  Revision : 1.0  initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_lo,
    input  logic [31:0] i_rword,
    output logic        o_illegal,
    output logic        o_misaligned,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Legality / alignment
    always_comb begin
        o_illegal    = 1'b0;
        o_misaligned = 1'b0;
        if (i_is_store) begin
            o_illegal = (i_funct3 > F3_W);
        end else if (i_is_load) begin
            o_illegal = (i_funct3 == 3'd3) || (i_funct3 == 3'd6) || (i_funct3 == 3'd7);
        end
        case (i_funct3)
            F3_H, F3_HU: o_misaligned = i_addr_lo[0];
            F3_W:        o_misaligned = (i_addr_lo != 2'b00);
            default:     o_misaligned = 1'b0;
        endcase
    end

    // Store lanes: data is replicated so the strobe alone selects the lane
    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
        case (i_funct3)
            F3_B: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            F3_H: begin
                o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_wstrb = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    // Load extraction
    always_comb begin
        w_byte = i_rword[7:0];
        case (i_ld_lo)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase
        w_half = i_ld_lo[1] ? i_rword[31:16] : i_rword[15:0];

        o_rdata = i_rword;
        case (i_ld_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {24'd0, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_HU:   o_rdata = {16'd0, w_half};
            default: o_rdata = i_rword;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : MEM-stage load/store unit. Issues one handshaked word access
//             per load/store, stalls the pipeline while it is outstanding,
//             aligns store data, extracts/extends load data and aborts an
//             access that waits longer than TIMEOUT cycles in REQ or RESP.
//  Ports    : clk, reset                       clock, sync active-high reset
//             MemRead, MemWrite, addr,
//             WriteData, funct3                EX/MEM access request
//             ReadData                         load result to MEM/WB
//             stall, err                       pipeline control / error pulse
//             mem_req, mem_we, mem_addr,
//             mem_wstrb, mem_wdata             bus request (registered)
//             mem_gnt, mem_rvalid, mem_rdata   bus response
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = c_timeout_default
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] WriteData,
    input  logic [2:0]  funct3,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int c_cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_tmo_limit = c_cnt_w'(TIMEOUT);

    lsu_state_t         r_state;
    lsu_state_t         w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [31:0]        r_rdata;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [3:0]         r_mem_wstrb;
    logic [31:0]        r_mem_wdata;
    logic [2:0]         r_ld_f3;
    logic [1:0]         r_ld_lo;

    logic        w_access;
    logic        w_is_store;
    logic        w_is_load;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_bad;
    logic        w_tmo;
    logic        w_enter_wait;
    logic [3:0]  w_st_strb;
    logic [31:0] w_st_data;
    logic [31:0] w_ld_data;

    assign w_access   = MemRead | MemWrite;
    assign w_is_store = MemWrite;
    assign w_is_load  = MemRead & ~MemWrite;
    assign w_bad      = w_illegal | w_misaligned;
    // With TIMEOUT=0 the limit is 0 and the counter never moves; the guard
    // keeps the abort path disabled.
    assign w_tmo      = (TIMEOUT != 0) && (r_cnt == c_tmo_limit);

    lsu_align u_align (
        .i_is_load    (w_is_load),
        .i_is_store   (w_is_store),
        .i_funct3     (funct3),
        .i_addr_lo    (addr[1:0]),
        .i_wdata      (WriteData),
        .i_ld_funct3  (r_ld_f3),
        .i_ld_lo      (r_ld_lo),
        .i_rword      (mem_rdata),
        .o_illegal    (w_illegal),
        .o_misaligned (w_misaligned),
        .o_wstrb      (w_st_strb),
        .o_wdata      (w_st_data),
        .o_rdata      (w_ld_data)
    );

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM next state / control outputs ----------------
    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        err    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (w_bad) begin
                        err = 1'b1;
                    end else begin
                        stall  = 1'b1;
                        w_next = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (w_tmo) begin
                    err    = 1'b1;
                    w_next = DONE;
                end else if (mem_gnt) begin
                    w_next = r_mem_we ? DONE : RESP;
                end
            end
            RESP: begin
                stall = 1'b1;
                if (w_tmo) begin
                    err    = 1'b1;
                    w_next = DONE;
                end else if (mem_rvalid) begin
                    w_next = DONE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ---------------- Timeout counter ----------------
    assign w_enter_wait = ((w_next == REQ)  && (r_state != REQ)) ||
                          ((w_next == RESP) && (r_state != RESP));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_enter_wait) begin
            r_cnt <= '0;
        end else if (((r_state == REQ) || (r_state == RESP)) && (r_cnt != c_tmo_limit)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ---------------- Bus request and load result registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wstrb <= '0;
            r_mem_wdata <= '0;
            r_ld_f3     <= '0;
            r_ld_lo     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        if (w_bad) begin
                            r_rdata <= '0;
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= w_is_store;
                            r_mem_addr  <= {addr[31:2], 2'b00};
                            r_mem_wstrb <= w_is_store ? w_st_strb : 4'b0000;
                            r_mem_wdata <= w_is_store ? w_st_data : 32'd0;
                            r_ld_f3     <= funct3;
                            r_ld_lo     <= addr[1:0];
                        end
                    end
                end
                REQ: begin
                    if (w_tmo) begin
                        r_mem_req <= 1'b0;
                        r_rdata   <= '0;
                    end else if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                    end
                end
                RESP: begin
                    if (w_tmo) begin
                        r_rdata <= '0;
                    end else if (mem_rvalid) begin
                        r_rdata <= w_ld_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ReadData  = r_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Directed self-checking bench for load_store_unit (TIMEOUT=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] addr, WriteData;
    logic [2:0]  funct3;
    logic [31:0] ReadData;
    logic        stall, err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .addr       (addr),
        .WriteData  (WriteData),
        .funct3     (funct3),
        .ReadData   (ReadData),
        .stall      (stall),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        MemRead   = rd;
        MemWrite  = wr;
        funct3    = f3;
        addr      = a;
        WriteData = wd;
    endtask

    initial begin
        reset = 1'b1;
        acc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        tick(); tick();
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", ReadData, 32'd0);
        tick();
        reset = 1'b0;

        // ---- SW 0x100, grant in first REQ cycle ----
        tick();
        acc(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF); #1;
        chk("sw_idle_stall", {31'd0, stall}, 32'd1);
        chk("sw_idle_req", {31'd0, mem_req}, 32'd0);
        tick();
        mem_gnt = 1'b1; #1;
        chk("sw_req", {31'd0, mem_req}, 32'd1);
        chk("sw_we", {31'd0, mem_we}, 32'd1);
        chk("sw_addr", mem_addr, 32'h100);
        chk("sw_wstrb", {28'd0, mem_wstrb}, 32'hF);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_req_stall", {31'd0, stall}, 32'd1);
        tick();
        mem_gnt = 1'b0; #1;
        chk("sw_done_stall", {31'd0, stall}, 32'd0);
        chk("sw_done_req", {31'd0, mem_req}, 32'd0);

        // ---- SB 0x103 ----
        tick();
        acc(1'b0, 1'b1, 3'd0, 32'h103, 32'h000000A5); #1;
        chk("sb_idle_stall", {31'd0, stall}, 32'd1);
        tick();
        mem_gnt = 1'b1; #1;
        chk("sb_addr", mem_addr, 32'h100);
        chk("sb_wstrb", {28'd0, mem_wstrb}, 32'h8);
        chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        tick();
        mem_gnt = 1'b0; #1;
        chk("sb_done_stall", {31'd0, stall}, 32'd0);

        // ---- LB 0x102, rvalid two cycles after grant ----
        tick();
        acc(1'b1, 1'b0, 3'd0, 32'h102, 32'd0); #1;
        chk("lb_idle_stall", {31'd0, stall}, 32'd1);
        tick();
        mem_gnt = 1'b1; #1;
        chk("lb_req", {31'd0, mem_req}, 32'd1);
        chk("lb_we", {31'd0, mem_we}, 32'd0);
        chk("lb_addr", mem_addr, 32'h100);
        tick();
        mem_gnt = 1'b0; #1;
        chk("lb_resp1_stall", {31'd0, stall}, 32'd1);
        chk("lb_resp1_req", {31'd0, mem_req}, 32'd0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h0080FF00; #1;
        chk("lb_resp2_stall", {31'd0, stall}, 32'd1);
        tick();
        mem_rvalid = 1'b0; #1;
        chk("lb_done_stall", {31'd0, stall}, 32'd0);
        chk("lb_rdata", ReadData, 32'hFFFFFF80);

        // ---- LBU on the same access ----
        tick();
        acc(1'b1, 1'b0, 3'd4, 32'h102, 32'd0); #1;
        chk("lbu_idle_stall", {31'd0, stall}, 32'd1);
        tick();
        mem_gnt = 1'b1; #1;
        tick();
        mem_gnt = 1'b0; #1;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h0080FF00; #1;
        chk("lbu_hold_prev", ReadData, 32'hFFFFFF80);
        tick();
        mem_rvalid = 1'b0; #1;
        chk("lbu_done_stall", {31'd0, stall}, 32'd0);
        chk("lbu_rdata", ReadData, 32'h00000080);

        // ---- LH 0x102, rvalid right after grant ----
        tick();
        acc(1'b1, 1'b0, 3'd1, 32'h102, 32'd0); #1;
        tick();
        mem_gnt = 1'b1; #1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80010000; #1;
        chk("lh_resp_stall", {31'd0, stall}, 32'd1);
        tick();
        mem_rvalid = 1'b0; #1;
        chk("lh_rdata", ReadData, 32'hFFFF8001);

        // ---- reset asserted during RESP, with an rvalid in flight ----
        tick();
        acc(1'b1, 1'b0, 3'd2, 32'h300, 32'd0); #1;
        tick();
        mem_gnt = 1'b1; #1;
        tick();
        mem_gnt = 1'b0; reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
        tick();
        reset = 1'b0; mem_rvalid = 1'b0;
        acc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0); #1;
        chk("rstmid_req", {31'd0, mem_req}, 32'd0);
        chk("rstmid_stall", {31'd0, stall}, 32'd0);
        chk("rstmid_rdata", ReadData, 32'd0);

        // ---- SW after reset; stray rvalid in IDLE is ignored ----
        tick();
        acc(1'b0, 1'b1, 3'd2, 32'h104, 32'h01234567);
        mem_rvalid = 1'b1; mem_rdata = 32'h55555555; #1;
        chk("sw2_idle_stall", {31'd0, stall}, 32'd1);
        tick();
        mem_rvalid = 1'b0; mem_gnt = 1'b1; #1;
        chk("sw2_addr", mem_addr, 32'h104);
        chk("sw2_wdata", mem_wdata, 32'h01234567);
        tick();
        mem_gnt = 1'b0; #1;
        chk("sw2_done_stall", {31'd0, stall}, 32'd0);
        chk("sw2_rdata", ReadData, 32'd0);

        // ---- LW 0x100 to set a nonzero ReadData ----
        tick();
        acc(1'b1, 1'b0, 3'd2, 32'h100, 32'd0); #1;
        tick();
        mem_gnt = 1'b1; #1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344; #1;
        tick();
        mem_rvalid = 1'b0; #1;
        chk("lw_rdata", ReadData, 32'h11223344);

        // ---- LW with grant but no rvalid -> timeout ----
        tick();
        acc(1'b1, 1'b0, 3'd2, 32'h200, 32'd0); #1;
        tick();
        mem_gnt = 1'b1; #1;
        tick();
        mem_gnt = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tmo_wait%0d_err", i), {31'd0, err}, 32'd0);
            chk($sformatf("tmo_wait%0d_stall", i), {31'd0, stall}, 32'd1);
            tick();
        end
        chk("tmo_err", {31'd0, err}, 32'd1);
        chk("tmo_err_stall", {31'd0, stall}, 32'd1);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678; #1;
        chk("tmo_done_stall", {31'd0, stall}, 32'd0);
        chk("tmo_done_err", {31'd0, err}, 32'd0);
        chk("tmo_rdata", ReadData, 32'd0);
        tick();
        acc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0); #1;
        chk("tmo_late_rdata", ReadData, 32'd0);
        chk("tmo_late_stall", {31'd0, stall}, 32'd0);
        mem_rvalid = 1'b0;

        // ---- misaligned LH and illegal funct3 ----
        tick();
        acc(1'b1, 1'b0, 3'd1, 32'h101, 32'd0); #1;
        chk("lh_mis_err", {31'd0, err}, 32'd1);
        chk("lh_mis_stall", {31'd0, stall}, 32'd0);
        tick();
        acc(1'b1, 1'b0, 3'd3, 32'h100, 32'd0); #1;
        chk("lh_mis_req", {31'd0, mem_req}, 32'd0);
        chk("ill_err", {31'd0, err}, 32'd1);
        chk("ill_stall", {31'd0, stall}, 32'd0);
        tick();
        acc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0); #1;
        chk("ill_req", {31'd0, mem_req}, 32'd0);
        chk("ill_err_gone", {31'd0, err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global bound so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
